// File: rtl/tdc_multichan.sv
// Multichannel event timestamper: per-channel capture slots arbitrated into one AXI-S output register.
// Pulse-to-tvalid latency is 2 cycles; the output register holds while tready is low, and channels that are still pending drop further events and set their lost flag.
module tdc_multichan #(
  parameter int NCH           = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int ARB_MODE      = 0,
  localparam int CH_BITS      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int DATA_WIDTH   = 1 + CH_BITS + COUNTER_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [NCH-1:0]        i_s,
  output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
  output logic                  o_m_axis_tvalid,
  input  logic                  i_m_axis_tready,
  output logic                  o_lost_any
);

  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic [COUNTER_WIDTH-1:0] r_ts [NCH];
  logic [NCH-1:0]           r_pend;
  logic [NCH-1:0]           r_lost;
  logic                     r_lost_any;
  logic                     r_vld;
  logic [DATA_WIDTH-1:0]    r_dat;
  logic [CH_BITS-1:0]       r_last_grant;

  logic [CH_BITS-1:0]       w_grant;
  logic [CH_BITS-1:0]       w_idx;
  logic                     w_found;
  logic                     w_load;
  logic                     w_take;
  logic [NCH-1:0]           w_drain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + COUNTER_WIDTH'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Arbitration is gated by i_en so nothing new is emitted while disabled.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ARB_MODE == 1) begin
        w_idx = CH_BITS'(i);
      end else begin
        w_idx = CH_BITS'((int'(r_last_grant) + 1 + i) % NCH);
      end
      if (!w_found && i_en && r_pend[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_load = !r_vld || i_m_axis_tready;
  assign w_take = w_load && w_found;

  always_comb begin
    w_drain = '0;
    for (int k = 0; k < NCH; k++) begin
      w_drain[k] = w_take && (w_grant == CH_BITS'(k));
    end
  end

  // A slot being drained this cycle is free for a same-cycle capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend     <= '0;
      r_lost     <= '0;
      r_lost_any <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_ts[k] <= '0;
      end
    end else if (!i_en) begin
      r_pend     <= '0;
      r_lost     <= '0;
      r_lost_any <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (i_s[k] && (!r_pend[k] || w_drain[k])) begin
          r_ts[k]   <= r_cnt;
          r_pend[k] <= 1'b1;
          r_lost[k] <= 1'b0;
        end else if (i_s[k]) begin
          r_lost[k]  <= 1'b1;
          r_lost_any <= 1'b1;
        end else if (w_drain[k]) begin
          r_pend[k] <= 1'b0;
          r_lost[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld        <= 1'b0;
      r_dat        <= '0;
      r_last_grant <= CH_BITS'(NCH - 1);
    end else if (w_load) begin
      r_vld <= w_found;
      if (w_found) begin
        r_dat        <= {r_lost[w_grant], w_grant, r_ts[w_grant]};
        r_last_grant <= w_grant;
      end
    end
  end

  assign o_m_axis_tdata  = r_dat;
  assign o_m_axis_tvalid = r_vld;
  assign o_lost_any      = r_lost_any;

endmodule

// File: tb/tb_tdc_multichan.sv
// Directed bench: dut0 uses default parameters, dut1 uses an 8-bit counter with fixed priority.
module tb_tdc_multichan;

  logic        clk;
  logic        i_rst;
  logic        i_en;
  logic [3:0]  i_s;
  logic        tready;

  logic [34:0] o0_tdata;
  logic        o0_tvalid;
  logic        o0_lost_any;
  logic [10:0] o1_tdata;
  logic        o1_tvalid;
  logic        o1_lost_any;

  int n_total = 0;
  int n_bad   = 0;

  tdc_multichan #(.NCH(4), .COUNTER_WIDTH(32), .ARB_MODE(0)) dut0 (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_en            (i_en),
    .i_s             (i_s),
    .o_m_axis_tdata  (o0_tdata),
    .o_m_axis_tvalid (o0_tvalid),
    .i_m_axis_tready (tready),
    .o_lost_any      (o0_lost_any)
  );

  tdc_multichan #(.NCH(4), .COUNTER_WIDTH(8), .ARB_MODE(1)) dut1 (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_en            (i_en),
    .i_s             (i_s),
    .o_m_axis_tdata  (o1_tdata),
    .o_m_axis_tvalid (o1_tvalid),
    .i_m_axis_tready (tready),
    .o_lost_any      (o1_lost_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves the bench 1 time unit into the first cycle after release (cnt = 0).
  task automatic do_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    i_rst  = 1'b1;
    i_en   = 1'b1;
    i_s    = 4'b0000;
    tready = 1'b1;
    step();
    step();
    chk("rst_vld0",  64'(o0_tvalid),   64'd0);
    chk("rst_dat0",  64'(o0_tdata),    64'd0);
    chk("rst_lost0", 64'(o0_lost_any), 64'd0);
    chk("rst_vld1",  64'(o1_tvalid),   64'd0);
    chk("rst_dat1",  64'(o1_tdata),    64'd0);
    i_rst = 1'b0;

    // single event at cnt=10, tvalid two cycles after the pulse
    steps(10);
    i_s = 4'b0001;
    chk("lat_t0", 64'(o0_tvalid), 64'd0);
    step();
    i_s = 4'b0000;
    chk("lat_t1", 64'(o0_tvalid), 64'd0);
    step();
    chk("lat_t2_vld", 64'(o0_tvalid), 64'd1);
    chk("lat_t2_dat", 64'(o0_tdata), 64'({1'b0, 2'd0, 32'd10}));
    step();
    chk("lat_t3_vld", 64'(o0_tvalid), 64'd0);

    // all four channels in one cycle at cnt=5, round-robin order
    do_reset();
    steps(5);
    i_s = 4'b1111;
    step();
    i_s = 4'b0000;
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("burst_vld%0d", k), 64'(o0_tvalid), 64'd1);
      chk($sformatf("burst_dat%0d", k), 64'(o0_tdata), 64'({1'b0, 2'(k), 32'd5}));
      step();
    end
    chk("burst_end", 64'(o0_tvalid), 64'd0);
    chk("burst_nolost", 64'(o0_lost_any), 64'd0);

    // overflow on ch2 while output is stalled by a ch0 record
    tready = 1'b0;
    do_reset();
    step();                 // cnt1
    i_s = 4'b0001;
    step();                 // cnt2
    i_s = 4'b0000;
    step();                 // cnt3
    i_s = 4'b0100;
    chk("ovf_hold_vld", 64'(o0_tvalid), 64'd1);
    chk("ovf_hold_dat", 64'(o0_tdata), 64'({1'b0, 2'd0, 32'd1}));
    step();                 // cnt4
    i_s = 4'b0000;
    steps(3);               // cnt7
    i_s = 4'b0100;
    chk("ovf_lost_pre", 64'(o0_lost_any), 64'd0);
    step();                 // cnt8
    i_s = 4'b0000;
    chk("ovf_lost_set", 64'(o0_lost_any), 64'd1);
    chk("ovf_stable", 64'(o0_tdata), 64'({1'b0, 2'd0, 32'd1}));
    tready = 1'b1;
    step();                 // cnt9
    chk("ovf_rec_vld", 64'(o0_tvalid), 64'd1);
    chk("ovf_rec_dat", 64'(o0_tdata), 64'({1'b1, 2'd2, 32'd3}));
    step();                 // cnt10
    chk("ovf_single", 64'(o0_tvalid), 64'd0);
    i_s = 4'b0100;
    step();                 // cnt11
    i_s = 4'b0000;
    step();                 // cnt12
    chk("ovf_next_dat", 64'(o0_tdata), 64'({1'b0, 2'd2, 32'd10}));
    chk("ovf_sticky", 64'(o0_lost_any), 64'd1);

    // disable: record held until accepted, pending ch3 flushed, falling-edge pulse ignored
    tready = 1'b0;
    i_s = 4'b1000;
    step();                 // cnt13
    i_s = 4'b0001;
    i_en = 1'b0;
    step();                 // A
    i_s = 4'b0000;
    chk("dis_hold_vld", 64'(o0_tvalid), 64'd1);
    chk("dis_hold_dat", 64'(o0_tdata), 64'({1'b0, 2'd2, 32'd10}));
    chk("dis_lost_clr", 64'(o0_lost_any), 64'd0);
    step();                 // B
    i_s = 4'b0010;
    tready = 1'b1;
    step();                 // C, cnt0
    i_s = 4'b0000;
    chk("dis_accepted", 64'(o0_tvalid), 64'd0);
    i_en = 1'b1;
    step();                 // D, cnt1
    chk("dis_flushed", 64'(o0_tvalid), 64'd0);
    i_s = 4'b0001;
    step();                 // E
    i_s = 4'b0000;
    chk("dis_idle", 64'(o0_tvalid), 64'd0);
    step();                 // F
    chk("en_restart", 64'(o0_tdata), 64'({1'b0, 2'd0, 32'd1}));

    // 8-bit counter wrap on dut1
    do_reset();
    steps(254);
    i_s = 4'b0010;
    step();                 // cnt255
    i_s = 4'b0000;
    step();                 // cnt0
    i_s = 4'b0010;
    chk("wrap_vld0", 64'(o1_tvalid), 64'd1);
    chk("wrap_dat0", 64'(o1_tdata), 64'({1'b0, 2'd1, 8'd254}));
    step();                 // cnt1
    i_s = 4'b0000;
    step();                 // cnt2
    chk("wrap_dat1", 64'(o1_tdata), 64'({1'b0, 2'd1, 8'd0}));

    // fixed priority (dut1) vs round-robin (dut0) with ch0 and ch3 competing
    do_reset();
    step();                 // cnt1
    i_s = 4'b0001;
    step();                 // cnt2
    i_s = 4'b1001;
    step();                 // cnt3
    i_s = 4'b0000;
    chk("prio_c3_fp", 64'(o1_tdata), 64'({1'b0, 2'd0, 8'd1}));
    step();                 // cnt4
    i_s = 4'b0001;
    chk("prio_c4_fp", 64'(o1_tdata), 64'({1'b0, 2'd0, 8'd2}));
    chk("prio_c4_rr", 64'(o0_tdata), 64'({1'b0, 2'd3, 32'd2}));
    step();                 // cnt5
    i_s = 4'b0000;
    chk("prio_c5_fp", 64'(o1_tdata), 64'({1'b0, 2'd3, 8'd2}));
    step();                 // cnt6
    chk("prio_c6_fp", 64'(o1_tdata), 64'({1'b0, 2'd0, 8'd4}));
    chk("prio_nolost", 64'(o1_lost_any), 64'd0);
    step();
    chk("prio_done", 64'(o1_tvalid), 64'd0);

    // reset while a record is stalled
    do_reset();
    tready = 1'b0;
    step();                 // cnt1
    i_s = 4'b0001;
    step();                 // cnt2
    i_s = 4'b0100;
    step();                 // cnt3
    i_s = 4'b0000;
    chk("rstmid_vld", 64'(o0_tvalid), 64'd1);
    i_rst = 1'b1;
    #1;
    chk("rstmid_vld0", 64'(o0_tvalid), 64'd0);
    chk("rstmid_dat0", 64'(o0_tdata), 64'd0);
    chk("rstmid_vld1", 64'(o1_tvalid), 64'd0);
    step();
    i_rst = 1'b0;
    tready = 1'b1;
    steps(3);
    chk("rstmid_nostale0", 64'(o0_tvalid), 64'd0);
    chk("rstmid_nostale1", 64'(o1_tvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
